operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 70 +++++++
 rtl/operand_fetch.sv | 102 ++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bundle: decoded-instruction input, register-file read port,
// bypass/write-back observation, downstream output and stall status.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              inValid;
  logic              inReady;
  logic [3:0]        inOp;
  logic [ADDR_W-1:0] inRsA;
  logic [ADDR_W-1:0] inRsB;
  logic              inUseA;
  logic              inUseB;
  logic [ADDR_W-1:0] inRd;
  logic              inRdWrite;
  logic [DATA_W-1:0] inImm;

  logic [ADDR_W-1:0] rfReadAddrA;
  logic [ADDR_W-1:0] rfReadAddrB;
  logic [DATA_W-1:0] rfReadDataA;
  logic [DATA_W-1:0] rfReadDataB;

  logic              exRdWrite;
  logic [ADDR_W-1:0] exRd;
  logic [DATA_W-1:0] exResult;
  logic              exResultValid;

  logic              wbWrite;
  logic [ADDR_W-1:0] wbAddr;
  logic [DATA_W-1:0] wbData;

  logic              schwapBusy;
  logic              flush;

  logic              outValid;
  logic              outReady;
  logic [3:0]        outOp;
  logic [DATA_W-1:0] outA;
  logic [DATA_W-1:0] outB;
  logic [DATA_W-1:0] outImm;
  logic [ADDR_W-1:0] outRd;
  logic              outRdWrite;

  logic              hazardStall;
  logic [7:0]        stallCount;

  // Stage side
  modport slave (
    input  inValid, inOp, inRsA, inRsB, inUseA, inUseB, inRd, inRdWrite, inImm,
    input  rfReadDataA, rfReadDataB,
    input  exRdWrite, exRd, exResult, exResultValid,
    input  wbWrite, wbAddr, wbData,
    input  schwapBusy, flush, outReady,
    output inReady, rfReadAddrA, rfReadAddrB,
    output outValid, outOp, outA, outB, outImm, outRd, outRdWrite,
    output hazardStall, stallCount
  );

  // Surrounding pipeline side
  modport master (
    output inValid, inOp, inRsA, inRsB, inUseA, inUseB, inRd, inRdWrite, inImm,
    output rfReadDataA, rfReadDataB,
    output exRdWrite, exRd, exResult, exResultValid,
    output wbWrite, wbAddr, wbData,
    output schwapBusy, flush, outReady,
    input  inReady, rfReadAddrA, rfReadAddrB,
    input  outValid, outOp, outA, outB, outImm, outRd, outRdWrite,
    input  hazardStall, stallCount
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read with ex/wb bypass, load-use and schwap-bank
// hazard stalls, and a one-entry output register with full-throughput handshake.
module operand_fetch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic           clk,
  input logic           resetN,
  operand_fetch_if.slave bus
);
  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  state_t            stateNext;
  logic              exHitA, exHitB, wbHitA, wbHitB;
  logic              loadUseA, loadUseB, schwapA, schwapB;
  logic              hazard;
  logic              ready;
  logic              accept;
  logic [DATA_W-1:0] operandA, operandB;
  logic [CNT_W-1:0]  stallCnt;

  logic [OP_W-1:0]   opQ;
  logic [DATA_W-1:0] aQ, bQ, immQ;
  logic [ADDR_W-1:0] rdQ;
  logic              rdWriteQ;

  assign bus.rfReadAddrA = bus.inRsA;
  assign bus.rfReadAddrB = bus.inRsB;

  assign exHitA = bus.exRdWrite && (bus.exRd == bus.inRsA);
  assign exHitB = bus.exRdWrite && (bus.exRd == bus.inRsB);
  assign wbHitA = bus.wbWrite && (bus.wbAddr == bus.inRsA);
  assign wbHitB = bus.wbWrite && (bus.wbAddr == bus.inRsB);

  // Youngest producer wins: execute result, then write-back, then register file
  assign operandA = (exHitA && bus.exResultValid) ? bus.exResult :
                    wbHitA ? bus.wbData : bus.rfReadDataA;
  assign operandB = (exHitB && bus.exResultValid) ? bus.exResult :
                    wbHitB ? bus.wbData : bus.rfReadDataB;

  assign loadUseA = bus.inUseA && exHitA && !bus.exResultValid;
  assign loadUseB = bus.inUseB && exHitB && !bus.exResultValid;
  assign schwapA  = bus.inUseA && (bus.inRsA[ADDR_W-1 -: 2] == 2'b11);
  assign schwapB  = bus.inUseB && (bus.inRsB[ADDR_W-1 -: 2] == 2'b11);
  assign hazard   = bus.inValid &&
                    (loadUseA || loadUseB || (bus.schwapBusy && (schwapA || schwapB)));

  assign ready  = ((state == EMPTY) || bus.outReady) && !hazard && !bus.flush;
  assign accept = bus.inValid && ready;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= EMPTY;
    else         state <= stateNext;
  end

  // Flush beats everything; a drain with a simultaneous accept stays FULL
  always_comb begin
    stateNext = state;
    if (bus.flush)                          stateNext = EMPTY;
    else if (accept)                        stateNext = FULL;
    else if (state == FULL && bus.outReady) stateNext = EMPTY;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      opQ      <= '0;
      aQ       <= '0;
      bQ       <= '0;
      immQ     <= '0;
      rdQ      <= '0;
      rdWriteQ <= 1'b0;
    end else if (accept) begin
      opQ      <= bus.inOp;
      aQ       <= operandA;
      bQ       <= operandB;
      immQ     <= bus.inImm;
      rdQ      <= bus.inRd;
      rdWriteQ <= bus.inRdWrite;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                           stallCnt <= '0;
    else if (hazard && stallCnt != CNT_MAX) stallCnt <= stallCnt + CNT_W'(1);
  end

  assign bus.inReady     = ready;
  assign bus.hazardStall = hazard;
  assign bus.stallCount  = stallCnt;
  assign bus.outValid    = (state == FULL);
  assign bus.outOp       = opQ;
  assign bus.outA        = aQ;
  assign bus.outB        = bQ;
  assign bus.outImm      = immQ;
  assign bus.outRd       = rdQ;
  assign bus.outRdWrite  = rdWriteQ;
endmodule
